// File: rtl/key_decoder.sv
// PS/2 scan-code byte stream to held-key levels (left/right/jump) with a stuck-key watchdog.
// Define ARROWS_EN to decode the extended arrow keys in addition to WASD/Space.
module key_decoder #(
  parameter int TIMEOUT_CYCLES = 130_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       left,
  output logic       right,
  output logic       jump
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_k_a, r_k_d, r_k_w, r_k_sp;
  logic            w_k_la, w_k_ra, w_k_ua;
  logic            w_ext, w_brk, w_expire;

  assign w_ext    = (r_state == EXT) || (r_state == EXT_BREAK);
  assign w_brk    = (r_state == BREAK) || (r_state == EXT_BREAK);
  // Expiry fires on the edge where the idle count steps onto TIMEOUT_CYCLES.
  assign w_expire = !rx_valid && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef ARROWS_EN
  logic r_k_la, r_k_ra, r_k_ua;
  assign w_k_la = r_k_la;
  assign w_k_ra = r_k_ra;
  assign w_k_ua = r_k_ua;
`else
  assign w_k_la = 1'b0;
  assign w_k_ra = 1'b0;
  assign w_k_ua = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k_a   <= 1'b0;
      r_k_d   <= 1'b0;
      r_k_w   <= 1'b0;
      r_k_sp  <= 1'b0;
`ifdef ARROWS_EN
      r_k_la  <= 1'b0;
      r_k_ra  <= 1'b0;
      r_k_ua  <= 1'b0;
`endif
      left    <= 1'b0;
      right   <= 1'b0;
      jump    <= 1'b0;
    end else begin
      if (rx_valid)
        r_cnt <= '0;
      else if (r_cnt != CW'(TIMEOUT_CYCLES))
        r_cnt <= r_cnt + 1'b1;

      if (rx_valid) begin
        case (rx_data)
          8'hE0: r_state <= EXT;
          8'hF0: r_state <= w_ext ? EXT_BREAK : BREAK;
          default: begin
            r_state <= IDLE;
            // Wrong-prefix bytes fall through the maps untouched.
            if (!w_ext) begin
              case (rx_data)
                8'h1C: r_k_a  <= !w_brk;
                8'h23: r_k_d  <= !w_brk;
                8'h1D: r_k_w  <= !w_brk;
                8'h29: r_k_sp <= !w_brk;
                default: ;
              endcase
            end
`ifdef ARROWS_EN
            else begin
              case (rx_data)
                8'h6B: r_k_la <= !w_brk;
                8'h74: r_k_ra <= !w_brk;
                8'h75: r_k_ua <= !w_brk;
                default: ;
              endcase
            end
`endif
          end
        endcase
      end else if (w_expire) begin
        r_state <= IDLE;
        r_k_a   <= 1'b0;
        r_k_d   <= 1'b0;
        r_k_w   <= 1'b0;
        r_k_sp  <= 1'b0;
`ifdef ARROWS_EN
        r_k_la  <= 1'b0;
        r_k_ra  <= 1'b0;
        r_k_ua  <= 1'b0;
`endif
      end

      left  <= r_k_a | w_k_la;
      right <= r_k_d | w_k_ra;
      jump  <= r_k_w | r_k_sp | w_k_ua;
    end
  end
endmodule

// File: tb/tb_key_decoder.sv
// Bench for key_decoder: held-key set model checked every cycle, plus directed literal checks.
module tb_key_decoder;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       left, right, jump;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .left(left), .right(right), .jump(jump)
  );

  always #5 clk = ~clk;

  // Model: set of held keys (0 A,1 D,2 W,3 Sp,4 La,5 Ra,6 Ua), pending prefix flags, idle counter.
  bit [6:0] mk;
  bit       m_ext, m_brk;
  int       m_idle;
  bit [2:0] m_exp;

  function automatic int key_index(bit ext, logic [7:0] b);
    if (!ext) begin
      if (b == 8'h1C) return 0;
      if (b == 8'h23) return 1;
      if (b == 8'h1D) return 2;
      if (b == 8'h29) return 3;
    end else begin
`ifdef ARROWS_EN
      if (b == 8'h6B) return 4;
      if (b == 8'h74) return 5;
      if (b == 8'h75) return 6;
`endif
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mk = '0; m_ext = 0; m_brk = 0; m_idle = 0; m_exp = '0;
    end else begin
      m_exp = {mk[0] | mk[4], mk[1] | mk[5], mk[2] | mk[3] | mk[6]};
      if (rx_valid) begin
        m_idle = 0;
        if (rx_data == 8'hE0) begin
          m_ext = 1; m_brk = 0;
        end else if (rx_data == 8'hF0) begin
          m_brk = 1;
        end else begin
          int k;
          k = key_index(m_ext, rx_data);
          if (k >= 0) mk[k] = !m_brk;
          m_ext = 0; m_brk = 0;
        end
      end else if (m_idle < T) begin
        m_idle++;
        if (m_idle == T) begin
          mk = '0; m_ext = 0; m_brk = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_total++;
      if ({left, right, jump} === m_exp) n_pass++;
      else $display("FAIL model_cmp t=%0t dut lrj=%b model lrj=%b", $time, {left, right, jump}, m_exp);
    end
  end

  task automatic check_lit(input string name, input bit [2:0] exp);
    n_total++;
    if ({left, right, jump} === exp && m_exp === exp) n_pass++;
    else $display("FAIL %s dut lrj=%b model lrj=%b expected %b", name, {left, right, jump}, m_exp, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam bit [2:0] ARW_R = `ifdef ARROWS_EN 3'b010 `else 3'b000 `endif;
  localparam bit [2:0] ARW_L = `ifdef ARROWS_EN 3'b100 `else 3'b000 `endif;

  initial begin
    logic [7:0] tbl [10];
    tbl = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1D, 8'h29, 8'h6B, 8'h74, 8'h75, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check_lit("reset", 3'b000);
    rst = 1'b0;
    idle(1);

    // Make then break, with exact latency
    rx_data = 8'h1C; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check_lit("make_not_yet", 3'b000);
    @(posedge clk); #1;
    check_lit("make_a", 3'b100);
    send(8'hF0);
    check_lit("break_prefix_hold", 3'b100);
    send(8'h1C);
    check_lit("break_a", 3'b000);

    // Two keys on one output
    send(8'h29); send(8'h1D);
    check_lit("jump_two", 3'b001);
    send(8'hF0); send(8'h29);
    check_lit("jump_one_left", 3'b001);
    send(8'hF0); send(8'h1D);
    check_lit("jump_none", 3'b000);

    // Extended codes
    send(8'hE0); send(8'h74);
    check_lit("ext_make_ra", ARW_R);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_lit("ext_break_ra", 3'b000);
    send(8'h74);
    check_lit("plain_74", 3'b000);
    send(8'hE0); send(8'h6B);
    check_lit("ext_make_la", ARW_L);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_lit("ext_break_la", 3'b000);

    // Prefix robustness
    send(8'hE0); send(8'h1C);
    check_lit("ext_1c_unmapped", 3'b000);
    send(8'h1C);
    check_lit("a_after_ext", 3'b100);
    send(8'hF0); send(8'h1C);
    send(8'h23);
    check_lit("d_held", 3'b010);
    send(8'hF0); send(8'hF0); send(8'h23);
    check_lit("double_f0_break", 3'b000);

    // Watchdog: strobe edge E, output clears at E+101
    send(8'h23);
    idle(99);
    check_lit("timeout_edge100", 3'b010);
    idle(1);
    check_lit("timeout_edge101", 3'b000);
    send(8'h23);
    idle(97);
    send(8'h23);
    check_lit("rearm_edge100", 3'b010);
    idle(1);
    check_lit("rearm_edge101", 3'b010);
    send(8'hF0); send(8'h23);
    check_lit("rearm_release", 3'b000);

    // Reset mid-sequence discards the partial break
    send(8'hE0); send(8'hF0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_lit("rst_mid", 3'b000);
    rst = 1'b0;
    send(8'h6B);
    check_lit("after_rst_6b", 3'b000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else if (r < 6) begin
        idle($urandom_range(95, 110));
      end
      rx_data = (r % 10 == 9) ? 8'($urandom) : tbl[$urandom_range(0, 8)];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      idle($urandom_range(1, 3));
    end

    idle(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
